// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file and its trap sequencer.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h4E0;
  localparam logic [11:0] CSR_MIE     = 12'h4E1;
  localparam logic [11:0] CSR_MIP     = 12'h4E2;
  localparam logic [11:0] CSR_MEPC    = 12'h4E3;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;
  localparam int unsigned MIE_MEIE       = 11;
  localparam int unsigned MIP_MEIP       = 11;

  typedef enum logic [2:0] {
    IDLE,
    T_MEPC,
    T_MSTAT,
    T_MIP,
    R_MSTAT,
    REDIR
  } trap_state_e;

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchroniser bringing the external interrupt line into the core clock domain.
module irq_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], d};
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap sequencer: serialises mepc/mstatus/mip updates for interrupts and MRET
// onto the CSR file's single write port, stalls the pipeline and issues the PC redirect.
module csr_trap_ctrl
  import csr_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] MTVEC_ADDR = 'h0000_0100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            interrupt,
  input  logic            inst_valid,
  input  logic [XLEN-1:0] pc,
  input  logic            is_mret,
  input  logic [XLEN-1:0] mstatus,
  input  logic [XLEN-1:0] mie,
  input  logic [XLEN-1:0] mip,
  input  logic [XLEN-1:0] mepc,
  output logic            csr_wr,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            stall,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);

  trap_state_e     state_q;
  logic            irq_s;
  logic            irq_pend_q;
  logic            ret_path_q;
  logic [XLEN-1:0] tgt_q;
  logic [XLEN-1:0] mstat_q;
  logic [XLEN-1:0] mip_q;
  logic            idle;
  logic            take_trap;
  logic            take_ret;
  logic            unused_mie;

  function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] ret_mstatus(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  irq_sync u_irq_sync (
    .clk (clk),
    .rst (rst),
    .d   (interrupt),
    .q   (irq_s)
  );

  assign unused_mie = ^{mie[XLEN-1:MIE_MEIE+1], mie[MIE_MEIE-1:0]};

  // Accept is blocked while rst is high so a reset cycle never starts a sequence.
  assign idle      = (state_q == IDLE);
  assign take_trap = !rst && idle && inst_valid && irq_pend_q &&
                     mstatus[MSTATUS_MIE] && mie[MIE_MEIE];
  assign take_ret  = !rst && idle && inst_valid && is_mret && !take_trap;
  assign stall     = !idle || take_trap || take_ret;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      irq_pend_q  <= 1'b0;
      ret_path_q  <= 1'b0;
      tgt_q       <= '0;
      mstat_q     <= '0;
      mip_q       <= '0;
      csr_wr      <= 1'b0;
      csr_waddr   <= '0;
      csr_wdata   <= '0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      csr_wr      <= 1'b0;
      csr_waddr   <= '0;
      csr_wdata   <= '0;
      redirect    <= 1'b0;
      redirect_pc <= '0;

      if (take_trap) begin
        irq_pend_q <= 1'b0;
      end else if (irq_s) begin
        irq_pend_q <= 1'b1;
      end

      // Outputs are loaded on entry to each state so they are valid throughout it.
      unique case (state_q)
        IDLE: begin
          if (take_trap) begin
            state_q    <= T_MEPC;
            ret_path_q <= 1'b0;
            tgt_q      <= pc;
            mstat_q    <= mstatus;
            mip_q      <= mip;
            csr_wr     <= 1'b1;
            csr_waddr  <= CSR_MEPC;
            csr_wdata  <= pc;
          end else if (take_ret) begin
            state_q    <= R_MSTAT;
            ret_path_q <= 1'b1;
            tgt_q      <= mepc;
            mstat_q    <= mstatus;
            mip_q      <= mip;
            csr_wr     <= 1'b1;
            csr_waddr  <= CSR_MSTATUS;
            csr_wdata  <= ret_mstatus(mstatus);
          end
        end
        T_MEPC: begin
          state_q   <= T_MSTAT;
          csr_wr    <= 1'b1;
          csr_waddr <= CSR_MSTATUS;
          csr_wdata <= trap_mstatus(mstat_q);
        end
        T_MSTAT: begin
          state_q   <= T_MIP;
          csr_wr    <= 1'b1;
          csr_waddr <= CSR_MIP;
          csr_wdata <= mip_q | (XLEN'(1) << MIP_MEIP);
        end
        T_MIP, R_MSTAT: begin
          state_q     <= REDIR;
          redirect    <= 1'b1;
          redirect_pc <= ret_path_q ? tgt_q : MTVEC_ADDR;
        end
        REDIR: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed scenarios followed by random traffic, checked every cycle against a schedule model.
module tb_csr_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst, interrupt, inst_valid, is_mret;
  logic [31:0] pc, mstatus, mie, mip, mepc;
  logic        csr_wr, stall, redirect;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata, redirect_pc;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic        redir;
    logic [31:0] rpc;
  } out_t;

  // Model: expected registered outputs for each upcoming cycle of an active sequence.
  out_t        exp_q[$];
  logic        pend;
  logic [1:0]  hist;  // interrupt samples at the last two edges, [1] is the older one

  csr_trap_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .interrupt   (interrupt),
    .inst_valid  (inst_valid),
    .pc          (pc),
    .is_mret     (is_mret),
    .mstatus     (mstatus),
    .mie         (mie),
    .mip         (mip),
    .mepc        (mepc),
    .csr_wr      (csr_wr),
    .csr_waddr   (csr_waddr),
    .csr_wdata   (csr_wdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic out_t rec(input logic wr, input logic [11:0] a, input logic [31:0] d,
                               input logic rd, input logic [31:0] rp);
    out_t r;
    r.wr = wr; r.addr = a; r.data = d; r.redir = rd; r.rpc = rp;
    return r;
  endfunction

  task automatic step();
    out_t cur;
    logic busy, acc_trap, acc_ret;
    @(negedge clk);
    busy = (exp_q.size() != 0);
    cur  = busy ? exp_q[0] : rec(1'b0, 12'h0, 32'h0, 1'b0, 32'h0);
    acc_trap = !rst && !busy && inst_valid && pend && mstatus[3] && mie[11];
    acc_ret  = !rst && !busy && inst_valid && is_mret && !acc_trap;
    chk("stall",       {31'b0, stall},    {31'b0, busy || acc_trap || acc_ret});
    chk("csr_wr",      {31'b0, csr_wr},   {31'b0, cur.wr});
    chk("csr_waddr",   {20'b0, csr_waddr}, {20'b0, cur.addr});
    chk("csr_wdata",   csr_wdata,         cur.data);
    chk("redirect",    {31'b0, redirect}, {31'b0, cur.redir});
    chk("redirect_pc", redirect_pc,       cur.rpc);
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      pend = 1'b0;
      hist = 2'b00;
    end else begin
      if (busy) cur = exp_q.pop_front();
      if (acc_trap) begin
        exp_q.push_back(rec(1'b1, 12'h4E3, pc, 1'b0, 32'h0));
        exp_q.push_back(rec(1'b1, 12'h4E0,
                            (mstatus & ~32'h1888) | 32'h1800 | (mstatus[3] ? 32'h80 : 32'h0),
                            1'b0, 32'h0));
        exp_q.push_back(rec(1'b1, 12'h4E2, mip | 32'h800, 1'b0, 32'h0));
        exp_q.push_back(rec(1'b0, 12'h0, 32'h0, 1'b1, 32'h100));
      end else if (acc_ret) begin
        exp_q.push_back(rec(1'b1, 12'h4E0,
                            (mstatus & ~32'h1888) | 32'h1880 | (mstatus[7] ? 32'h8 : 32'h0),
                            1'b0, 32'h0));
        exp_q.push_back(rec(1'b0, 12'h0, 32'h0, 1'b1, mepc));
      end
      if (acc_trap) pend = 1'b0;
      else if (hist[1]) pend = 1'b1;
      hist = {hist[0], interrupt};
    end
    #1;
  endtask

  task automatic irq_pulse_wait();
    inst_valid = 1'b0;
    interrupt  = 1'b1;
    step();
    interrupt  = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    pend = 1'b0; hist = 2'b00;
    rst = 1'b1; interrupt = 1'b0; inst_valid = 1'b0; is_mret = 1'b0;
    pc = 32'h0; mstatus = 32'h0; mie = 32'h0; mip = 32'h0; mepc = 32'h0;
    repeat (2) step();
    rst = 1'b0;
    step();

    // Basic trap at pc 0x40
    mstatus = 32'h8; mie = 32'h800;
    irq_pulse_wait();
    inst_valid = 1'b1; pc = 32'h40;
    repeat (6) step();

    // Masked interrupt, then enabled
    mstatus = 32'h0;
    interrupt = 1'b1; step(); interrupt = 1'b0;
    repeat (4) step();
    mstatus = 32'h8; pc = 32'h60;
    repeat (6) step();

    // MRET
    mstatus = 32'h1880; mepc = 32'h44; pc = 32'h48; is_mret = 1'b1;
    step();
    is_mret = 1'b0;
    repeat (3) step();

    // Interrupt and MRET together: trap wins
    mstatus = 32'h8; mie = 32'h800;
    irq_pulse_wait();
    pc = 32'h80; is_mret = 1'b1; inst_valid = 1'b1;
    step();
    is_mret = 1'b0;
    repeat (5) step();

    // Pending interrupt held while inst_valid is low
    irq_pulse_wait();
    repeat (4) step();
    inst_valid = 1'b1; pc = 32'hC0;
    repeat (6) step();

    // Reset during T_MSTAT
    irq_pulse_wait();
    inst_valid = 1'b1; pc = 32'hD0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (6) step();

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 7) == 0) interrupt = ~interrupt;
      inst_valid = ($urandom_range(0, 3) != 0);
      is_mret    = ($urandom_range(0, 4) == 0);
      pc         = $urandom & 32'hFFFF_FFFC;
      mstatus    = $urandom;
      mie        = $urandom | ($urandom_range(0, 3) != 0 ? 32'h800 : 32'h0);
      mip        = $urandom;
      mepc       = $urandom & 32'hFFFF_FFFC;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
